// File: rtl/ame_num_scale.sv
// Scales a latched vector of signed numerators by 2^-exp (symmetric rounding,
// saturation) and streams one registered result per cycle.
module ame_num_scale #(
  parameter int COMP_DATA_BITS = 64,
  parameter int NUM_ELEM       = 6,
  parameter int OUT_DATA_BITS  = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               init_i,
  input  logic [NUM_ELEM*COMP_DATA_BITS-1:0] num_data_i,
  input  logic                               exp_done_i,
  input  logic [$clog2(COMP_DATA_BITS)-1:0]  exp_data_i,
  output logic                               busy_o,
  output logic                               out_valid_o,
  output logic [$clog2(NUM_ELEM)-1:0]        out_index_o,
  output logic [OUT_DATA_BITS-1:0]           out_data_o,
  output logic                               done_o
);

  localparam int EXP_BITS = $clog2(COMP_DATA_BITS);
  localparam int IDX_BITS = $clog2(NUM_ELEM);
  localparam int EW       = COMP_DATA_BITS + 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ELEM - 1);

  typedef enum logic [1:0] {IDLE, WAIT_EXP, SHIFT} state_e;

  state_e                    state_q, state_d;
  logic [IDX_BITS-1:0]       idx_q, idx_d;
  logic [EXP_BITS-1:0]       exp_q, exp_d;
  logic [COMP_DATA_BITS-1:0] num_q [NUM_ELEM];
  logic [COMP_DATA_BITS-1:0] num_d [NUM_ELEM];
  logic [COMP_DATA_BITS-1:0] num_in [NUM_ELEM];

  logic                      out_valid_q, out_valid_d;
  logic [IDX_BITS-1:0]       out_index_q, out_index_d;
  logic [OUT_DATA_BITS-1:0]  out_data_q, out_data_d;
  logic                      done_q, done_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEM; gi++) begin : g_unpack
      assign num_in[gi] = num_data_i[gi*COMP_DATA_BITS +: COMP_DATA_BITS];
    end
  endgenerate

  // Element arithmetic: one extra bit so |-2^(W-1)| and the rounding bias never overflow.
  logic [COMP_DATA_BITS-1:0] x;
  logic                      x_neg;
  logic [EW-1:0]             mag, bias, rnd;
  logic signed [EW:0]        y;
  logic                      fits;
  logic [OUT_DATA_BITS-1:0]  sat;

  always_comb begin
    x     = num_q[idx_q];
    x_neg = x[COMP_DATA_BITS-1];
    mag   = x_neg ? ({1'b0, ~x} + EW'(1)) : {1'b0, x};
    bias  = (exp_q != '0) ? (EW'(1) << (exp_q - 1'b1)) : '0;
    rnd   = (mag + bias) >> exp_q;
    y     = x_neg ? -$signed({1'b0, rnd}) : $signed({1'b0, rnd});
    fits  = (y[EW:OUT_DATA_BITS-1] == '0) || (y[EW:OUT_DATA_BITS-1] == '1);
    if (fits) begin
      sat = y[OUT_DATA_BITS-1:0];
    end else if (y[EW]) begin
      sat = {1'b1, {(OUT_DATA_BITS-1){1'b0}}};
    end else begin
      sat = {1'b0, {(OUT_DATA_BITS-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    exp_d       = exp_q;
    num_d       = num_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_i) begin
          num_d = num_in;
          if (exp_done_i) begin
            exp_d   = exp_data_i;
            idx_d   = '0;
            state_d = SHIFT;
          end else begin
            state_d = WAIT_EXP;
          end
        end
      end
      WAIT_EXP: begin
        if (exp_done_i) begin
          exp_d   = exp_data_i;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid_d = 1'b1;
        out_index_d = idx_q;
        out_data_d  = sat;
        if (idx_q == LAST_IDX) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      exp_q       <= '0;
      num_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_q       <= exp_d;
      num_q       <= num_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_index_o = out_index_q;
  assign out_data_o  = out_data_q;
  assign done_o      = done_q;

endmodule

// File: doc/ame_num_scale.md
# ame_num_scale

Downstream consumer of the AME approximate-log2 stage. It latches a vector of signed numerators and waits for the 6-bit shift exponent the approximator produces for the shared denominator. It then emits each numerator divided by 2^exp with symmetric rounding and saturation, one element per cycle, as a registered stream. This stream feeds the affine-parameter solver in place of true division.

## Interface
- COMP_DATA_BITS, 64, numerator width, signed two's complement; must equal the approximator's input width.
- NUM_ELEM, 6, numerators per job.
- OUT_DATA_BITS, 32, result width, signed.
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- init_i  in  1  job start; sampled in IDLE only.
- num_data_i  in  NUM_ELEM*COMP_DATA_BITS  packed numerators; element k is at [k*COMP_DATA_BITS +: COMP_DATA_BITS]; sampled with init_i.
- exp_done_i  in  1  exponent valid strobe, from the approximator's done.
- exp_data_i  in  $clog2(COMP_DATA_BITS)  shift exponent.
- busy_o  out  1  job in progress (state != IDLE).
- out_valid_o  out  1  result strobe.
- out_index_o  out  $clog2(NUM_ELEM)  element index of out_data_o.
- out_data_o  out  OUT_DATA_BITS  scaled result.
- done_o  out  1  pulse with the last element's out_valid_o.

## Operation
- FSM states: IDLE, WAIT_EXP, SHIFT.
- IDLE, init_i=1:
  - Latch all numerators and go to WAIT_EXP.
  - If exp_done_i=1 in the same cycle, also latch exp_data_i and go straight to SHIFT.
- IDLE, init_i=0: exp_done_i is ignored.
- WAIT_EXP: on exp_done_i, latch exp and go to SHIFT with idx=0. init_i is ignored.
- SHIFT:
  - Process element idx each cycle; idx increments by 1.
  - At idx=NUM_ELEM-1, return to IDLE.
  - init_i and exp_done_i are ignored.
- Per-element arithmetic:
  - m = |x|, computed in COMP_DATA_BITS+1 bits so that -2^63 is exact.
  - r = (m + (exp>0 ? 2^(exp-1) : 0)) >> exp, computed in COMP_DATA_BITS+1 bits with no overflow.
  - Restore the sign: y = x<0 ? -r : r.
  - Saturate y to [-2^(OUT_DATA_BITS-1), 2^(OUT_DATA_BITS-1)-1].
- exp=0 (zero or unit denominator from the approximator) passes x through, saturated.
- out_data_o and out_index_o hold their last values when out_valid_o=0.
- Reset values of all outputs: 0. Internal state resets to IDLE, idx=0, exp=0, numerators 0.
- Reset mid-job aborts the job. No partial done_o is produced.

## Timing
- Cycle 0: init_i sampled.
- Cycle 1: WAIT_EXP, busy_o=1. exp_done_i is expected here when the approximator is started in cycle 0.
- Cycles 2..NUM_ELEM+1: SHIFT for idx 0..NUM_ELEM-1.
- Outputs are registered, one cycle after SHIFT: out_valid_o=1 in cycles 3..NUM_ELEM+2, with out_index_o=0..NUM_ELEM-1.
- done_o=1 only in cycle NUM_ELEM+2, coincident with the last out_valid_o.
- busy_o=1 in cycles 1..NUM_ELEM+1 and 0 in cycle NUM_ELEM+2. A new init_i is accepted in cycle NUM_ELEM+2 (back-to-back jobs).
- With exp_done_i coincident with init_i, every output event moves one cycle earlier.
- WAIT_EXP has no timeout; the block waits indefinitely for exp_done_i.
- out_valid_o is never back-pressured; the consumer must accept one element per cycle.

## Test plan
- Basic rounding, exp=3:
  - Stimulus: numerators {100, -100, 4, -4, 3, 0}, exp_done_i in cycle 1.
  - Required: outputs {13, -13, 1, -1, 0, 0} in cycles 3..8 with indices 0..5; done_o only in cycle 8; busy_o high in cycles 1..7.
- Pass-through, exp=0:
  - Stimulus: {7, -7, 2^31-1, -2^31, 1, -1}.
  - Required: outputs identical to inputs.
- Saturation, exp=2:
  - Stimulus: {2^40, -2^40, -2^63, 2^63-1, 2^33-4, -(2^33)}.
  - Required: {0x7FFFFFFF, 0x80000000, 0x80000000, 0x7FFFFFFF, 0x7FFFFFFF, 0x80000000}.
- Maximum shift, exp=63:
  - Stimulus: {2^62, -2^62, 2^62-1, -2^63, 0, 1}.
  - Required: {1, -1, 0, -1, 0, 0}.
- Control:
  - exp_done_i pulsed in IDLE with no job: no outputs.
  - init_i pulsed during SHIFT: ignored, current job unchanged.
  - init_i coincident with exp_done_i: first out_valid_o in cycle 2.
  - Back-to-back job started in the done_o cycle: its first out_valid_o in cycle NUM_ELEM+5.
- Reset mid-job: assert rst_n_i=0 during SHIFT with idx=2.
  - Required: all outputs 0 immediately; no done_o.
  - After release, a fresh job completes normally.
